// File: rtl/mem_arbiter_if.sv
// Request/response and shared-RAM bundle seen by the memory arbiter.
// master: the requesters and the RAM model; slave: the arbiter itself.
interface mem_arbiter_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
);
    logic [1:0]          iREN;
    logic [2*ADDR_W-1:0] iaddr;
    logic [1:0]          dREN;
    logic [1:0]          dWEN;
    logic [2*ADDR_W-1:0] daddr;
    logic [2*WORD_W-1:0] dstore;
    logic [1:0]          ihit;
    logic [1:0]          dhit;
    logic [WORD_W-1:0]   rdata;
    logic                err;
    logic [ADDR_W-1:0]   ramaddr;
    logic [WORD_W-1:0]   ramstore;
    logic                ramREN;
    logic                ramWEN;
    logic [WORD_W-1:0]   ramload;
    logic                ramready;

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  ihit, dhit, rdata, err, ramaddr, ramstore, ramREN, ramWEN
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output ihit, dhit, rdata, err, ramaddr, ramstore, ramREN, ramWEN
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter for the instruction and data ports of two cores.
// One transaction in flight; data beats instruction, round robin per class.
//
// state  | meaning
// IDLE   | arbitrate pending requests, latch the winner
// ACCESS | RAM strobe held, waiting for ramready or the timeout
// RESP   | strobes low, one-cycle hit (and err on timeout) to the winner
module mem_arbiter #(
    parameter int WORD_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                rr_d_q;
    logic                rr_i_q;
    logic                core_q;
    logic                data_q;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   store_q;
    logic [WORD_W-1:0]   rdata_q;
    logic                ren_q;
    logic                wen_q;
    logic [1:0]          ihit_q;
    logic [1:0]          dhit_q;
    logic                err_q;

    logic [1:0]          dreq_d;
    logic                gnt_valid_d;
    logic                gnt_data_d;
    logic                gnt_core_d;
    logic                gnt_write_d;
    logic [ADDR_W-1:0]   gnt_addr_d;
    logic [WORD_W-1:0]   gnt_store_d;

    // Pick the winner among the requests visible this cycle.
    always_comb begin
        dreq_d      = bus.dREN | bus.dWEN;
        gnt_data_d  = |dreq_d;
        gnt_valid_d = gnt_data_d | (|bus.iREN);
        if (gnt_data_d) begin
            gnt_core_d = dreq_d[rr_d_q] ? rr_d_q : ~rr_d_q;
        end else begin
            gnt_core_d = bus.iREN[rr_i_q] ? rr_i_q : ~rr_i_q;
        end
        // A data port asserting both strobes is treated as a write.
        gnt_write_d = gnt_data_d & bus.dWEN[gnt_core_d];
        if (gnt_data_d) begin
            gnt_addr_d = gnt_core_d ? bus.daddr[2*ADDR_W-1:ADDR_W] : bus.daddr[ADDR_W-1:0];
        end else begin
            gnt_addr_d = gnt_core_d ? bus.iaddr[2*ADDR_W-1:ADDR_W] : bus.iaddr[ADDR_W-1:0];
        end
        gnt_store_d = gnt_core_d ? bus.dstore[2*WORD_W-1:WORD_W] : bus.dstore[WORD_W-1:0];
    end

    // Transaction sequencer; every output comes straight from a register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_d_q  <= 1'b0;
            rr_i_q  <= 1'b0;
            core_q  <= 1'b0;
            data_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            rdata_q <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            ihit_q  <= '0;
            dhit_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            ihit_q <= '0;
            dhit_q <= '0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_valid_d) begin
                        core_q  <= gnt_core_d;
                        data_q  <= gnt_data_d;
                        write_q <= gnt_write_d;
                        addr_q  <= gnt_addr_d;
                        store_q <= gnt_store_d;
                        ren_q   <= ~gnt_write_d;
                        wen_q   <= gnt_write_d;
                        cnt_q   <= '0;
                        if (gnt_data_d) begin
                            rr_d_q <= ~gnt_core_d;
                        end else begin
                            rr_i_q <= ~gnt_core_d;
                        end
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.ramready || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                        // ramready on the last allowed cycle still counts as success.
                        if (bus.ramready && !write_q) begin
                            rdata_q <= bus.ramload;
                        end
                        err_q <= ~bus.ramready;
                        if (data_q) begin
                            dhit_q[core_q] <= 1'b1;
                        end else begin
                            ihit_q[core_q] <= 1'b1;
                        end
                        cnt_q   <= '0;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ihit     = ihit_q;
    assign bus.dhit     = dhit_q;
    assign bus.err      = err_q;
    assign bus.rdata    = rdata_q;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.ramREN   = ren_q;
    assign bus.ramWEN   = wen_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: four requesters, a RAM responder with
// per-transaction latency, a transaction-level reference model and two
// scoreboard monitors (RAM side and hit side).
module tb_mem_arbiter;
    localparam int WORD_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   drive_en = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   mcyc = 0;
    int   last_rst_cyc = -1;

    mem_arbiter_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] store;
        int          lat;
        logic [31:0] load;
    } ram_exp_t;

    typedef struct {
        int          cyc;
        int          port;
        logic        err;
        logic [31:0] rdata;
    } hit_exp_t;

    ram_exp_t ram_q[$];
    hit_exp_t hit_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, mcyc);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, mcyc);
    endtask

    // Reference model: one transaction at a time, scheduled by its latency.
    // A grant decided in cycle t puts strobes up in t+1, the hit in t+k+1,
    // and the arbiter is free again in t+k+2 (k = RAM latency or TIMEOUT).
    int          free_at = 0;
    logic        m_rr_d = 1'b0;
    logic        m_rr_i = 1'b0;
    logic [31:0] m_rdata = '0;

    always @(posedge clk) begin : model
        logic [1:0]  dreq;
        logic [1:0]  pend;
        logic        is_d;
        logic        ptr;
        logic        c;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;
        int          lat;
        int          k;
        mcyc++;
        if (rst) begin
            m_rr_d = 1'b0;
            m_rr_i = 1'b0;
            m_rdata = '0;
            free_at = mcyc;
            ram_q.delete();
            hit_q.delete();
            last_rst_cyc = mcyc;
        end else if (mcyc - 1 >= free_at) begin
            dreq = bus.dREN | bus.dWEN;
            if (dreq != 2'b00 || bus.iREN != 2'b00) begin
                is_d = (dreq != 2'b00);
                pend = is_d ? dreq : bus.iREN;
                ptr  = is_d ? m_rr_d : m_rr_i;
                c    = pend[ptr] ? ptr : !ptr;
                if (is_d) m_rr_d = !c;
                else      m_rr_i = !c;
                wr    = is_d && bus.dWEN[c];
                addr  = is_d ? bus.daddr[c*ADDR_W +: ADDR_W] : bus.iaddr[c*ADDR_W +: ADDR_W];
                store = bus.dstore[c*WORD_W +: WORD_W];
                lat   = int'($urandom_range(0, TIMEOUT));
                k     = (lat == 0) ? TIMEOUT : lat;
                load  = $urandom;
                if (!wr && lat != 0) m_rdata = load;
                ram_q.push_back('{mcyc, wr, addr, store, lat, load});
                hit_q.push_back('{mcyc + k, (is_d ? 2 : 0) + int'(c), (lat == 0), m_rdata});
                free_at = mcyc + k + 1;
            end
        end
    end

    // RAM responder and RAM-side monitor.
    int       rcnt = 0;
    int       rlim = TIMEOUT;
    ram_exp_t cur;

    always @(negedge clk) begin : ram_side
        if (last_rst_cyc < 0 || mcyc == last_rst_cyc) begin
            rcnt = 0;
            bus.ramready = 1'b0;
            bus.ramload  = '0;
        end else if (bus.ramREN === 1'b1 || bus.ramWEN === 1'b1) begin
            if (rcnt == 0) begin
                if (ram_q.size() == 0) begin
                    fail_now("unexpected_strobe", 1, 0);
                    cur = '{mcyc, 1'b0, '0, '0, 0, '0};
                end else begin
                    cur = ram_q.pop_front();
                    check("strobe_cycle", 64'(mcyc), 64'(cur.cyc));
                    check("ramWEN", 64'(bus.ramWEN), 64'(cur.is_wr));
                    check("ramREN", 64'(bus.ramREN), 64'(!cur.is_wr));
                    check("ramaddr", 64'(bus.ramaddr), 64'(cur.addr));
                    if (cur.is_wr) check("ramstore", 64'(bus.ramstore), 64'(cur.store));
                end
                rlim = (cur.lat == 0) ? TIMEOUT : cur.lat;
            end
            rcnt++;
            if (rcnt > rlim) fail_now("strobe_length", rcnt, rlim);
            bus.ramready = (rcnt == cur.lat);
            bus.ramload  = (rcnt == cur.lat) ? cur.load : $urandom;
        end else begin
            if (rcnt != 0 && rcnt != rlim) fail_now("strobe_length", rcnt, rlim);
            rcnt = 0;
            while (ram_q.size() > 0 && ram_q[0].cyc < mcyc) begin
                fail_now("missing_strobe", mcyc, ram_q[0].cyc);
                void'(ram_q.pop_front());
            end
            // ramready outside an access is noise the arbiter must ignore.
            bus.ramready = 1'($urandom_range(0, 1));
            bus.ramload  = $urandom;
        end
    end

    // Hit-side monitor.
    always @(negedge clk) begin : hit_side
        logic [3:0] hv;
        hit_exp_t   e;
        if (last_rst_cyc >= 0 && mcyc != last_rst_cyc) begin
            hv = {bus.dhit, bus.ihit};
            while (hit_q.size() > 0 && hit_q[0].cyc < mcyc) begin
                fail_now("missing_hit", mcyc, hit_q[0].cyc);
                void'(hit_q.pop_front());
            end
            if (hv != 4'b0000 || bus.err !== 1'b0) begin
                if (hit_q.size() == 0) begin
                    fail_now("unexpected_hit", int'(hv), 0);
                end else begin
                    e = hit_q.pop_front();
                    check("hit_cycle", 64'(mcyc), 64'(e.cyc));
                    check("hit_port", 64'(hv), 64'(4'b0001 << e.port));
                    check("err", 64'(bus.err), 64'(e.err));
                    check("rdata", 64'(bus.rdata), 64'(e.rdata));
                end
            end
        end
    end

    // Requesters: raise, hold until hit, drop the cycle after; sometimes
    // withdraw early or scribble over address/data while waiting.
    always @(negedge clk) begin : requesters
        logic [3:0] hv;
        logic       req;
        int         c;
        int         m;
        if (!drive_en) begin
            bus.iREN = '0;
            bus.dREN = '0;
            bus.dWEN = '0;
            if (last_rst_cyc < 0) begin
                bus.iaddr  = '0;
                bus.daddr  = '0;
                bus.dstore = '0;
            end
        end else begin
            hv = {bus.dhit, bus.ihit};
            for (int p = 0; p < 4; p++) begin
                c = p % 2;
                req = (p < 2) ? bus.iREN[c] : (bus.dREN[c] | bus.dWEN[c]);
                if (hv[p] || (req && $urandom_range(0, 19) == 0)) begin
                    if (p < 2) bus.iREN[c] = 1'b0;
                    else begin
                        bus.dREN[c] = 1'b0;
                        bus.dWEN[c] = 1'b0;
                    end
                end else if (!req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0)) begin
                    if (p < 2) begin
                        bus.iaddr[c*ADDR_W +: ADDR_W] = $urandom & 32'hFFFF_FFFC;
                        bus.iREN[c] = 1'b1;
                    end else begin
                        bus.daddr[c*ADDR_W +: ADDR_W]  = $urandom & 32'hFFFF_FFFC;
                        bus.dstore[c*WORD_W +: WORD_W] = $urandom;
                        if (!req) begin
                            m = int'($urandom_range(0, 2));
                            bus.dREN[c] = (m != 1);
                            bus.dWEN[c] = (m != 0);
                        end
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ihit"}, 64'(bus.ihit), 64'(0));
        check({tag, "_dhit"}, 64'(bus.dhit), 64'(0));
        check({tag, "_err"}, 64'(bus.err), 64'(0));
        check({tag, "_rdata"}, 64'(bus.rdata), 64'(0));
        check({tag, "_ramREN"}, 64'(bus.ramREN), 64'(0));
        check({tag, "_ramWEN"}, 64'(bus.ramWEN), 64'(0));
        check({tag, "_ramaddr"}, 64'(bus.ramaddr), 64'(0));
    endtask

    initial begin
        int run;
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        drive_en = 1'b1;
        repeat (500) @(negedge clk);

        for (int r = 0; r < 3; r++) begin
            run = 0;
            n = 0;
            while (run < 2 && n < 200) begin
                @(negedge clk);
                run = (bus.ramREN === 1'b1 || bus.ramWEN === 1'b1) ? run + 1 : 0;
                n++;
            end
            if (run < 2) fail_now("wait_for_access", run, 2);
            rst = 1'b1;
            @(negedge clk);
            check_all_zero("midreset");
            rst = 1'b0;
            repeat (200) @(negedge clk);
        end

        drive_en = 1'b0;
        n = 0;
        while ((hit_q.size() > 0 || ram_q.size() > 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("drain_hits", 64'(hit_q.size()), 64'(0));
        check("drain_ram", 64'(ram_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares a single RAM port between the instruction and data request ports of two pipelined datapaths (cores 0 and 1).
- Accepts level-held requests and grants one transaction at a time.
- Sequences the RAM handshake and returns read data with a one-cycle hit pulse to the granted requester.
- Sits between the per-core cache/datapath interfaces and the shared RAM.

Parameters:
- WORD_W, 32, data width of loads and stores.
- ADDR_W, 32, address width.
- TIMEOUT, 64, maximum cycles spent in ACCESS waiting for ramready before the transaction is aborted; must be at least 2.
- CNT_W, 7, width of the timeout counter; must hold TIMEOUT.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  2  instruction read request, bit c = core c.
- iaddr  in  2*ADDR_W  instruction addresses; core c at [c*ADDR_W +: ADDR_W].
- dREN  in  2  data read request per core.
- dWEN  in  2  data write request per core.
- daddr  in  2*ADDR_W  data addresses per core.
- dstore  in  2*WORD_W  store data per core.
- ihit  out  2  one-cycle instruction-complete pulse per core.
- dhit  out  2  one-cycle data-complete pulse per core.
- rdata  out  WORD_W  read data, valid in the cycle a hit is pulsed.
- err  out  1  one-cycle pulse, coincident with the hit, when the transaction timed out.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramload  in  WORD_W  RAM read data.
- ramready  in  1  RAM completion, valid while a strobe is high.

Behaviour:
- Reset:
  - All outputs are 0.
  - State is IDLE.
  - Timeout counter is 0.
  - Both round-robin pointers (rr_d, rr_i) are 0 (core 0 preferred).
  - Reset asserted in any state aborts the transaction immediately; no hit is pulsed and the RAM strobes drop the next cycle.
- States: IDLE, ACCESS, RESP.
- IDLE, arbitration:
  - Data requests (dREN|dWEN) beat instruction requests.
  - Within a class, the core named by that class's pointer wins if requesting; otherwise the other core wins.
  - On a grant, register the requester id (core, class), address, store data and the rw flag, then go to ACCESS.
  - Write wins if dREN and dWEN are both high.
  - The pointer of the granted class is set to the other core. The other class's pointer is unchanged.
  - No request: stay in IDLE.
- ACCESS:
  - ramaddr, ramstore, ramREN/ramWEN are driven from registered values (registered outputs); exactly one strobe is high.
  - The counter increments each cycle.
  - If ramready: register ramload into rdata (reads only; writes leave rdata unchanged), clear the counter, go to RESP.
  - If the counter reaches TIMEOUT-1 without ramready: clear the counter, set err_pending, go to RESP.
- RESP:
  - Strobes are 0.
  - Pulse the granted hit bit (ihit[c] or dhit[c]) for exactly one cycle.
  - err follows err_pending for that cycle.
  - Go to IDLE.
  - rdata holds its value until the next read completes.
- Latency:
  - A request first seen in IDLE at cycle t drives the strobes from t+1.
  - If ramready arrives at cycle t+k (k≥1), the hit is at t+k+1.
  - Back-to-back throughput is one transaction per k+2 cycles.
- Request withdrawn mid-transaction: the transaction still completes and the hit is still pulsed; the requester ignores it. Requests are sampled only in IDLE.
- Address or store-data changes during ACCESS have no effect, because the values are registered at grant.
- A hit is never pulsed to more than one requester, and only one bit of ihit|dhit is ever high.
- A request still held in the RESP cycle is re-arbitrated in the following IDLE cycle. A requester must drop its request in the cycle after its hit, or it is serviced again.
- ramready outside ACCESS is ignored.

Test Plan:
- Single read: core0 dREN, daddr=0x40, RAM returns 0xDEADBEEF with ramready 3 cycles after the strobe rises -> ramREN high 3 cycles at ramaddr 0x40; dhit[0] pulses 1 cycle later with rdata=0xDEADBEEF; err=0.
- Priority: the same cycle has iREN[0], iREN[1] and dWEN[1] (daddr=0x80, dstore=0x1234) -> core1 data write granted first (ramWEN, ramstore=0x1234); then instruction core0, then instruction core1, each with one ihit pulse.
- Round robin: both cores hold dREN continuously, RAM ready in 1 cycle -> grants alternate 0,1,0,1; the dhit pulse sequence is 01,10,01,10 spaced 3 cycles apart.
- Timeout with TIMEOUT=4: core1 iREN, ramready never asserted -> ramREN high exactly 4 cycles; then ihit[1]=1 and err=1 for one cycle; state returns to IDLE.
- Reset mid-ACCESS: RST asserted 2 cycles into a read -> next cycle all outputs 0, no hit pulsed; after release with core0 dREN pending, core0 is granted normally.
- Read/write conflict: dREN[0]=dWEN[0]=1 -> ramWEN only, ramREN stays 0, rdata unchanged, dhit[0] pulses once.
